muldiv_seq: RTL and testbench

Iterative multiply/divide unit with HI/LO registers, sequenced alongside the single-cycle instruction controller. It executes the SPECIAL funct codes mult, multu, div, divu, mfhi, mthi, mflo and mtlo. Multiply and divide run as 32-iteration radix-2 operations. A combinational stall tells the controller to hold the current instruction while the unit is busy.

---
 rtl/muldiv_seq_if.sv | 28 ++
 rtl/muldiv_seq.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: controller <-> multiply/divide unit bundle.
//   master (controller): drives start, func, a, b; observes rdata, busy, stall, hi, lo.
//   slave  (muldiv_seq): the reverse.
//   start  - a muldiv-class instruction is issued this cycle
//   func   - SPECIAL funct field (16 mfhi, 17 mthi, 18 mflo, 19 mtlo, 24..27 mult/multu/div/divu)
//   a, b   - rs / rt operands
//   rdata  - HI when func selects mfhi, LO otherwise
//   busy   - multiply/divide sequence in progress
//   stall  - start while busy; controller must hold the instruction
//   hi, lo - architectural HI / LO registers
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, func, a, b,
                  input  rdata, busy, stall, hi, lo);
  modport slave  (input  start, func, a, b,
                  output rdata, busy, stall, hi, lo);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 multiply/divide unit with HI/LO registers.
//   clk    - rising-edge clock
//   _reset - asynchronous active-low reset (aborts any operation, clears HI/LO)
//   bus    - muldiv_seq_if.slave: start/func/a/b in, rdata/busy/stall/hi/lo out
// An operation takes one accept edge, WIDTH iteration edges and one fix-up
// edge that applies sign correction and writes HI/LO.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         _reset,
  muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MTHI = 6'd17;
  localparam logic [5:0] F_MTLO = 6'd19;

  localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0]      ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      LAST_C  = CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  // mul: {partial product, multiplier}; div: low half is dividend shifting into quotient
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  // multiplicand magnitude for mul, divisor magnitude for div
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               op_div_q, op_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dz_q, dz_d;

  logic               busy_s;
  logic               is_muldiv_s;
  logic               sa_s, sb_s;
  logic [WIDTH-1:0]   ma_s, mb_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_diff_s;

  assign busy_s      = (state_q != S_IDLE);
  assign is_muldiv_s = (bus.func[5:2] == 4'b0110);
  // func[0]==0 selects the signed variants (mult, div)
  assign sa_s        = ~bus.func[0] & bus.a[WIDTH-1];
  assign sb_s        = ~bus.func[0] & bus.b[WIDTH-1];
  assign ma_s        = sa_s ? (~bus.a + ONE_W) : bus.a;
  assign mb_s        = sb_s ? (~bus.b + ONE_W) : bus.b;

  assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                       (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  // partial remainder is WIDTH+1 bits once the next dividend bit is shifted in
  assign div_shift_s = {rem_q, acc_q[WIDTH-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
  // when div_ge_s holds the true difference is < divisor, so WIDTH bits suffice
  assign div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_q;

  assign bus.busy  = busy_s;
  assign bus.stall = bus.start & busy_s;
  assign bus.rdata = (bus.func == F_MFHI) ? hi_q : lo_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  // Next-state, iteration datapath and HI/LO write-back.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opnd_d    = opnd_q;
    op_div_d  = op_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && is_muldiv_s) begin
          op_div_d  = bus.func[1];
          neg_d     = sa_s ^ sb_s;
          rem_neg_d = sa_s;
          dz_d      = bus.func[1] & (bus.b == ZERO_W);
          count_d   = ZERO_C;
          rem_d     = ZERO_W;
          if (bus.func[1]) begin
            acc_d   = {ZERO_W, ma_s};
            opnd_d  = mb_s;
            state_d = S_DIV;
          end else begin
            acc_d   = {ZERO_W, mb_s};
            opnd_d  = ma_s;
            state_d = S_MUL;
          end
        end else if (bus.start && (bus.func == F_MTHI)) begin
          hi_d = bus.a;
        end else if (bus.start && (bus.func == F_MTLO)) begin
          lo_d = bus.a;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d   = {mul_sum_s, acc_q[WIDTH-1:1]};
        count_d = count_q + ONE_C;
        if (count_q == LAST_C) begin
          state_d = S_FIX;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        rem_d   = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
        acc_d   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge_s};
        count_d = count_q + ONE_C;
        if (count_q == LAST_C) begin
          state_d = S_FIX;
        end else begin
          state_d = S_DIV;
        end
      end
      S_FIX: begin
        if (op_div_q) begin
          // divide by zero: quotient all ones, remainder sign-restores to the original a
          if (dz_q) begin
            lo_d = {WIDTH{1'b1}};
          end else if (neg_q) begin
            lo_d = ~acc_q[WIDTH-1:0] + ONE_W;
          end else begin
            lo_d = acc_q[WIDTH-1:0];
          end
          hi_d = rem_neg_q ? (~rem_q + ONE_W) : rem_q;
        end else begin
          {hi_d, lo_d} = neg_q ? (~acc_q + ONE_2W) : acc_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous abort on reset.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q   <= S_IDLE;
      count_q   <= ZERO_C;
      hi_q      <= ZERO_W;
      lo_q      <= ZERO_W;
      acc_q     <= {ZERO_W, ZERO_W};
      rem_q     <= ZERO_W;
      opnd_q    <= ZERO_W;
      op_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opnd_q    <= opnd_d;
      op_div_q  <= op_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  muldiv_seq_if #(.WIDTH(32)) bus_if ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    ._reset (rst_n),
    .bus    (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // issue one mul/div op and run it to completion, checking the busy window
  task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    int bcnt;
    bus_if.func  = f;
    bus_if.a     = x;
    bus_if.b     = y;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    bcnt = 0;
    repeat (33) begin
      if (bus_if.busy === 1'b1) bcnt++;
      tick();
    end
    chk("busy_len", 32'(bcnt), 32'd33);
    chk("busy_end", {31'd0, bus_if.busy}, 32'd0);
  endtask

  initial begin
    int scnt;
    int hchg;
    total = 0;
    bad   = 0;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.func  = 6'd0;
    bus_if.a     = 32'd0;
    bus_if.b     = 32'd0;
    tick();
    tick();
    chk("rst_hi", bus_if.hi, 32'd0);
    chk("rst_lo", bus_if.lo, 32'd0);
    chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("rst_stall", {31'd0, bus_if.stall}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: multu max*max
    run_op(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hi", bus_if.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus_if.lo, 32'h0000_0001);

    // 2: mult -3*7, then mflo
    run_op(6'd24, 32'hFFFF_FFFD, 32'd7);
    chk("mult_hi", bus_if.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus_if.lo, 32'hFFFF_FFEB);
    bus_if.func  = 6'd18;
    bus_if.start = 1'b1;
    #1;
    chk("mflo_rdata", bus_if.rdata, 32'hFFFF_FFEB);
    chk("mflo_stall", {31'd0, bus_if.stall}, 32'd0);
    tick();
    bus_if.start = 1'b0;

    // signed multiply corner cases
    run_op(6'd24, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mult_nn_hi", bus_if.hi, 32'h0000_0000);
    chk("mult_nn_lo", bus_if.lo, 32'h0000_0001);
    run_op(6'd24, 32'h8000_0000, 32'h8000_0000);
    chk("mult_min_hi", bus_if.hi, 32'h4000_0000);
    chk("mult_min_lo", bus_if.lo, 32'h0000_0000);

    // 3: divides
    run_op(6'd26, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo", bus_if.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus_if.hi, 32'hFFFF_FFFF);
    run_op(6'd27, 32'd100, 32'd0);
    chk("divu0_lo", bus_if.lo, 32'hFFFF_FFFF);
    chk("divu0_hi", bus_if.hi, 32'd100);
    run_op(6'd27, 32'd100, 32'd7);
    chk("divu_lo", bus_if.lo, 32'd14);
    chk("divu_hi", bus_if.hi, 32'd2);
    run_op(6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo", bus_if.lo, 32'h8000_0000);
    chk("div_ovf_hi", bus_if.hi, 32'h0000_0000);
    run_op(6'd26, 32'hFFFF_FFF9, 32'd0);
    chk("div0_neg_lo", bus_if.lo, 32'hFFFF_FFFF);
    chk("div0_neg_hi", bus_if.hi, 32'hFFFF_FFF9);

    // 4: multu 3*5 with mfhi held by stall through the busy window
    bus_if.func  = 6'd25;
    bus_if.a     = 32'd3;
    bus_if.b     = 32'd5;
    bus_if.start = 1'b1;
    tick();
    bus_if.func = 6'd16;
    scnt = 0;
    hchg = 0;
    repeat (33) begin
      if (bus_if.stall === 1'b1) scnt++;
      if (bus_if.hi !== 32'hFFFF_FFF9) hchg++;
      tick();
    end
    chk("stall_cycles", 32'(scnt), 32'd33);
    chk("hi_held", 32'(hchg), 32'd0);
    chk("release_stall", {31'd0, bus_if.stall}, 32'd0);
    chk("release_rdata", bus_if.rdata, 32'd0);
    chk("release_lo", bus_if.lo, 32'd15);
    tick();
    bus_if.start = 1'b0;

    // 5: mthi / mtlo while idle, plus an unlisted func
    bus_if.func  = 6'd17;
    bus_if.a     = 32'h1234_5678;
    bus_if.start = 1'b1;
    #1;
    chk("mthi_stall", {31'd0, bus_if.stall}, 32'd0);
    tick();
    chk("mthi_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("mthi_hi", bus_if.hi, 32'h1234_5678);
    bus_if.func = 6'd19;
    bus_if.a    = 32'h9ABC_DEF0;
    tick();
    chk("mtlo_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("mtlo_lo", bus_if.lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", bus_if.hi, 32'h1234_5678);
    bus_if.func = 6'd0;
    bus_if.a    = 32'hDEAD_BEEF;
    #1;
    chk("bad_func_stall", {31'd0, bus_if.stall}, 32'd0);
    tick();
    chk("bad_func_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("bad_func_hi", bus_if.hi, 32'h1234_5678);
    chk("bad_func_lo", bus_if.lo, 32'h9ABC_DEF0);
    bus_if.start = 1'b0;

    // 6: async reset mid-mult
    bus_if.func  = 6'd24;
    bus_if.a     = 32'd6;
    bus_if.b     = 32'd7;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    repeat (10) tick();
    chk("mid_busy", {31'd0, bus_if.busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_hi", bus_if.hi, 32'd0);
    chk("abort_lo", bus_if.lo, 32'd0);
    chk("abort_busy", {31'd0, bus_if.busy}, 32'd0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    bus_if.func  = 6'd16;
    bus_if.start = 1'b1;
    #1;
    chk("post_mfhi", bus_if.rdata, 32'd0);
    chk("post_stall", {31'd0, bus_if.stall}, 32'd0);
    tick();
    bus_if.start = 1'b0;
    run_op(6'd24, 32'd6, 32'd7);
    chk("post_mult_lo", bus_if.lo, 32'd42);
    chk("post_mult_hi", bus_if.hi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
